mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the single-port 1024x32 working memory used by the DTW processor. It shares the one memory port between requester 0 (DTW core: template/score traffic) and requester 1 (host loader/result readback). Each granted transfer becomes exactly one registered memory command. Arbitration is round-robin, with an optional per-requester lock for atomic bursts and a lock timeout.

## Interface

Parameters:
- AW, 10: memory address width.
- DW, 32: memory data width.
- LOCK_MAX, 16: maximum consecutive cycles a lock may be held; must be ≥1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active high.
- rN_req  in  1  transfer request (N = 0, 1); hold until granted.
- rN_wr  in  1  1 = write, 0 = read.
- rN_addr  in  AW  word address.
- rN_wdata  in  DW  write data.
- rN_lock  in  1  keep ownership after this transfer.
- rN_gnt  out  1  combinational; the transfer occurs in a cycle where rN_req & rN_gnt.
- rN_rvalid  out  1  read data valid for requester N.
- rN_rdata  out  DW  equals mem_rdata, unregistered; qualified by rN_rvalid.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data; valid the cycle after the memory's access edge.
- mem_WR  out  1  registered; 1 = write, 0 = read.
- mem_CS  out  1  registered chip select, active low.

## Operation

- States: IDLE, LOCK0, LOCK1. Pointer `last` holds the most recently granted requester; it resets to 1 so that r0 wins first.
- IDLE grant rules:
  - Exactly one requester with req set: that requester is granted.
  - Both requesters with req set: grant the requester that is not `last`.
  - Neither requester with req set: no grant.
- LOCKn: only requester n can be granted. The other requester's gnt stays 0 regardless of its req.
- Transfer by requester n with lock = 1: next state is LOCKn.
- Transfer by requester n with lock = 0: next state is IDLE.
- Each grant updates `last` to n.
- Lock counter:
  - Cleared on entering LOCKn; increments every cycle in LOCKn.
  - When it reaches LOCK_MAX, the state returns to IDLE on the next edge, regardless of req or lock. A transfer granted in that final cycle still completes.
  - The transfer's lock bit is ignored at that moment.
- Command register, on the edge that ends a transfer cycle:
  - mem_CS = 0.
  - mem_WR = rn_wr.
  - mem_addr = rn_addr.
  - mem_wdata = rn_wdata.
- Command register, when there is no transfer: mem_CS = 1 and mem_WR = 0; mem_addr and mem_wdata hold their values.
- Read return tracking: a 2-stage shift of (valid, id) tracks reads. Writes produce no rvalid. rN_rvalid = stage2.valid & (stage2.id == N).
- At most one grant per cycle; both gnt signals are never high together.

## Timing

- Reset values:
  - mem_CS = 1, mem_WR = 0, mem_addr = 0, mem_wdata = 0.
  - Both gnt = 0 while rst = 1.
  - Both rvalid = 0.
  - State = IDLE, lock counter = 0, `last` = 1.
- Read latency. For a transfer in cycle t:
  - The command is on the mem_* pins during t+1.
  - The memory samples at the edge ending t+1.
  - rN_rvalid is high and mem_rdata is valid during t+2.
- Throughput: one transfer per cycle. Back-to-back reads return data on consecutive cycles, in order.
- Write latency: the memory is updated at the edge ending t+1. A read of the same address granted in t+1 or later returns the new data.
- gnt depends combinationally on req, on the state, and on `last`. Requesters must not make req depend combinationally on gnt.
- Reset mid-operation: in-flight reads are discarded. rvalid is 0 in every cycle from the cycle after rst is sampled high, and the first post-reset rvalid appears no earlier than 2 cycles after the first post-reset grant.
- Locked owner deasserts req: no transfer occurs, the lock counter still advances, and mem_CS = 1.

## Test plan

- Single read: MEM[5] = 0xDEADBEEF; r0 reads addr 5 in cycle t. Required: r0_gnt = 1 in t; mem_CS = 0 and mem_addr = 5 in t+1; r0_rvalid = 1 and r0_rdata = 0xDEADBEEF in t+2; r1_rvalid = 0 throughout.
- Contention: r0 and r1 both hold reads, r0 to addr 1..4 and r1 to addr 11..14. Required: grants alternate r0, r1, r0, r1, ... starting with r0 after reset; each requester's rvalid carries its own data in order.
- Write then read: r1 writes 0x12345678 to addr 20 in cycle t; r0 reads addr 20 in t+1. Required: r0_rdata = 0x12345678 in t+3.
- Locked burst: r1 issues 3 reads with lock = 1, 1, 0 while r0_req is held. Required: r0_gnt = 0 for all three; r0 is granted in the cycle after r1's lock = 0 transfer.
- Lock timeout: LOCK_MAX = 4; r1 transfers with lock = 1, then drops req; r0_req is held. Required: r0_gnt stays 0 for 4 cycles, then goes to 1; mem_CS = 1 during the wait.
- Reset mid-read: r0 reads in cycle t and rst is high in t+1. Required: r0_rvalid = 0 in t+2; mem_CS = 1 and all outputs at reset values after the reset edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter with lock for a single-port working memory
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   rN_req/wr/addr/wdata/lock    requester N transfer request (N = 0, 1)
//   rN_gnt                       combinational grant; a transfer happens when rN_req & rN_gnt
//   rN_rvalid, rN_rdata          read return for requester N (rdata is mem_rdata passed through)
//   mem_addr/wdata/WR/CS         registered memory command (CS active low)
//   mem_rdata                    memory read data, valid the cycle after the access edge
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_WR,
  output logic          mem_CS
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCK0 = 2'd1;
  localparam logic [1:0] S_LOCK1 = 2'd2;

  logic [1:0]    state, state_nx;
  logic          last;
  logic [CW-1:0] lock_cnt;

  logic          xfer0, xfer1, xfer;
  logic          sel_wr, sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_lock, lock_done;

  // Read-return pipeline: stage 1 is the command cycle, stage 2 the data cycle.
  logic rd_v1, rd_id1, rd_v2, rd_id2;

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (r0_req && r1_req) begin
            // Both asking: the one that did not win last time goes now.
            r0_gnt = last;
            r1_gnt = ~last;
          end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
          end
        end
        S_LOCK0: r0_gnt = r0_req;
        S_LOCK1: r1_gnt = r1_req;
        default: ;
      endcase
    end
  end

  assign xfer0 = r0_req & r0_gnt;
  assign xfer1 = r1_req & r1_gnt;
  assign xfer  = xfer0 | xfer1;

  assign sel_wr    = xfer1 ? r1_wr    : r0_wr;
  assign sel_lock  = xfer1 ? r1_lock  : r0_lock;
  assign sel_addr  = xfer1 ? r1_addr  : r0_addr;
  assign sel_wdata = xfer1 ? r1_wdata : r0_wdata;

  assign in_lock   = (state == S_LOCK0) || (state == S_LOCK1);
  // Final locked cycle: the counter is about to reach LOCK_MAX, so ownership
  // is released at this edge whatever the owner's lock bit says.
  assign lock_done = in_lock && (lock_cnt == LOCK_LAST);

  always_comb begin
    state_nx = state;
    if (!(in_lock || state == S_IDLE)) begin
      state_nx = S_IDLE;
    end else if (lock_done) begin
      state_nx = S_IDLE;
    end else if (xfer) begin
      if (sel_lock) begin
        state_nx = xfer1 ? S_LOCK1 : S_LOCK0;
      end else begin
        state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      lock_cnt  <= '0;
      mem_CS    <= 1'b1;
      mem_WR    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_v1     <= 1'b0;
      rd_id1    <= 1'b0;
      rd_v2     <= 1'b0;
      rd_id2    <= 1'b0;
    end else begin
      state <= state_nx;

      // Counter restarts from zero on entry to a lock and runs while locked.
      if (state == S_IDLE || state_nx == S_IDLE) begin
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + CW'(1);
      end

      if (xfer) begin
        last      <= xfer1;
        mem_CS    <= 1'b0;
        mem_WR    <= sel_wr;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end else begin
        mem_CS <= 1'b1;
        mem_WR <= 1'b0;
      end

      rd_v1  <= xfer & ~sel_wr;
      rd_id1 <= xfer1;
      rd_v2  <= rd_v1;
      rd_id2 <= rd_id1;
    end
  end

  assign r0_rvalid = rd_v2 & ~rd_id2;
  assign r1_rvalid = rd_v2 &  rd_id2;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_wr, r0_lock, r0_gnt, r0_rvalid;
  logic [9:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_wr, r1_lock, r1_gnt, r1_rvalid;
  logic [9:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_WR, mem_CS;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int row    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(10), .DW(32), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_WR(mem_WR), .mem_CS(mem_CS)
  );

  // Single-port synchronous memory: one access per edge, read data next cycle.
  always @(posedge clk) begin
    if (mem_CS == 1'b0) begin
      if (mem_WR) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  typedef struct {
    logic        rst;
    logic        q0, w0, l0;
    logic [9:0]  a0;
    logic        q1, w1, l1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic        eg0, eg1, ecs, ewr;
    logic [9:0]  eaddr;
    logic        erv0, erv1;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rs, input int q0, input int w0, input int l0, input int a0,
                              input int q1, input int w1, input int l1, input int a1, input logic [31:0] d1,
                              input int eg0, input int eg1, input int ecs, input int ewr, input int eaddr,
                              input int erv0, input int erv1, input logic [31:0] erd);
    vec_t v;
    v.rst = rs[0];  v.q0 = q0[0];   v.w0 = w0[0];   v.l0 = l0[0];   v.a0 = a0[9:0];
    v.q1 = q1[0];   v.w1 = w1[0];   v.l1 = l1[0];   v.a1 = a1[9:0]; v.d1 = d1;
    v.eg0 = eg0[0]; v.eg1 = eg1[0]; v.ecs = ecs[0]; v.ewr = ewr[0]; v.eaddr = eaddr[9:0];
    v.erv0 = erv0[0]; v.erv1 = erv1[0]; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_wr = 0; r0_lock = 0; r0_addr = '0; r0_wdata = 32'hFEED_FACE;
    r1_req = 0; r1_wr = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    mem[5] = 32'hDEAD_BEEF;
    rst = 1'b1;
    idle_inputs();

    //              rst q0 w0 l0 a0   q1 w1 l1 a1  d1            g0 g1 cs wr addr rv0 rv1 rd
    vecs.push_back(mk(1, 1,0,0,5,   1,0,0,11, 0,            0,0,1,0,0,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,5,   0,0,0,0,  0,            1,0,1,0,0,   0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,5,   0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,5,   1,0,32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,5,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,1,   1,0,0,11, 0,            1,0,1,0,0,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,2,   1,0,0,11, 0,            0,1,0,0,1,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,2,   1,0,0,12, 0,            1,0,0,0,11,  1,0,pat(1)));
    vecs.push_back(mk(0, 1,0,0,3,   1,0,0,12, 0,            0,1,0,0,2,   0,1,pat(11)));
    vecs.push_back(mk(0, 1,0,0,3,   1,0,0,13, 0,            1,0,0,0,12,  1,0,pat(2)));
    vecs.push_back(mk(0, 1,0,0,4,   1,0,0,13, 0,            0,1,0,0,3,   0,1,pat(12)));
    vecs.push_back(mk(0, 1,0,0,4,   1,0,0,14, 0,            1,0,0,0,13,  1,0,pat(3)));
    vecs.push_back(mk(0, 0,0,0,0,   1,0,0,14, 0,            0,1,0,0,4,   0,1,pat(13)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,14,  1,0,pat(4)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,14,  0,1,pat(14)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,14,  0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   1,1,0,20, 32'h12345678, 0,1,1,0,14,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,20,  0,0,0,0,  0,            1,0,0,1,20,  0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,20,  0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,20,  1,0,32'h12345678));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,20,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,7,   1,0,1,30, 0,            0,1,1,0,20,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,7,   1,0,1,31, 0,            0,1,0,0,30,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,7,   1,0,0,32, 0,            0,1,0,0,31,  0,1,pat(30)));
    vecs.push_back(mk(0, 1,0,0,7,   0,0,0,0,  0,            1,0,0,0,32,  0,1,pat(31)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,7,   0,1,pat(32)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,7,   1,0,pat(7)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,7,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,8,   1,0,1,33, 0,            0,1,1,0,7,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,8,   0,0,0,0,  0,            0,0,0,0,33,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,8,   0,0,0,0,  0,            0,0,1,0,33,  0,1,pat(33)));
    vecs.push_back(mk(0, 1,0,0,8,   0,0,0,0,  0,            0,0,1,0,33,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,8,   0,0,0,0,  0,            0,0,1,0,33,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,8,   0,0,0,0,  0,            1,0,1,0,33,  0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,8,   0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,8,   1,0,pat(8)));
    vecs.push_back(mk(0, 0,0,0,0,   1,0,1,34, 0,            0,1,1,0,8,   0,0,0));
    vecs.push_back(mk(0, 1,0,0,9,   1,0,1,35, 0,            0,1,0,0,34,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,9,   1,0,1,36, 0,            0,1,0,0,35,  0,1,pat(34)));
    vecs.push_back(mk(0, 1,0,0,9,   1,0,1,37, 0,            0,1,0,0,36,  0,1,pat(35)));
    vecs.push_back(mk(0, 1,0,0,9,   1,0,1,38, 0,            0,1,0,0,37,  0,1,pat(36)));
    vecs.push_back(mk(0, 1,0,0,9,   1,0,0,39, 0,            1,0,0,0,38,  0,1,pat(37)));
    vecs.push_back(mk(0, 0,0,0,0,   1,0,0,39, 0,            0,1,0,0,9,   0,1,pat(38)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,39,  1,0,pat(9)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,39,  0,1,pat(39)));
    vecs.push_back(mk(0, 1,0,1,40,  1,0,0,41, 0,            1,0,1,0,39,  0,0,0));
    vecs.push_back(mk(0, 1,0,0,42,  1,0,0,41, 0,            1,0,0,0,40,  0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,   1,0,0,41, 0,            0,1,0,0,42,  1,0,pat(40)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,0,0,41,  1,0,pat(42)));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0,  0,            0,0,1,0,41,  0,1,pat(41)));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      row = i;
      @(posedge clk); #1;
      rst = vecs[i].rst;
      r0_req = vecs[i].q0; r0_wr = vecs[i].w0; r0_lock = vecs[i].l0; r0_addr = vecs[i].a0;
      r1_req = vecs[i].q1; r1_wr = vecs[i].w1; r1_lock = vecs[i].l1; r1_addr = vecs[i].a1;
      r1_wdata = vecs[i].d1;
      @(negedge clk);
      chk("r0_gnt", 32'(r0_gnt), 32'(vecs[i].eg0));
      chk("r1_gnt", 32'(r1_gnt), 32'(vecs[i].eg1));
      chk("mem_CS", 32'(mem_CS), 32'(vecs[i].ecs));
      chk("mem_WR", 32'(mem_WR), 32'(vecs[i].ewr));
      chk("mem_addr", 32'(mem_addr), 32'(vecs[i].eaddr));
      chk("r0_rvalid", 32'(r0_rvalid), 32'(vecs[i].erv0));
      chk("r1_rvalid", 32'(r1_rvalid), 32'(vecs[i].erv1));
      if (vecs[i].erv0) chk("r0_rdata", r0_rdata, vecs[i].erd);
      if (vecs[i].erv1) chk("r1_rdata", r1_rdata, vecs[i].erd);
    end

    // Reset while a read is in flight.
    row = 1000;
    @(posedge clk); #1;
    idle_inputs();
    r0_req = 1; r0_addr = 10'd5;
    @(negedge clk);
    chk("rst_seq_gnt0", 32'(r0_gnt), 32'd1);

    row = 1001;
    @(posedge clk); #1;
    rst = 1; r0_req = 1; r1_req = 1;
    @(negedge clk);
    chk("rst_gnt0", 32'(r0_gnt), 32'd0);
    chk("rst_gnt1", 32'(r1_gnt), 32'd0);
    chk("rst_cmd_cs", 32'(mem_CS), 32'd0);
    chk("rst_wdata_before", mem_wdata, 32'hFEED_FACE);

    row = 1002;
    @(posedge clk); #1;
    rst = 0; idle_inputs();
    @(negedge clk);
    chk("post_rst_rv0", 32'(r0_rvalid), 32'd0);
    chk("post_rst_rv1", 32'(r1_rvalid), 32'd0);
    chk("post_rst_cs", 32'(mem_CS), 32'd1);
    chk("post_rst_wr", 32'(mem_WR), 32'd0);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    chk("post_rst_wdata", mem_wdata, 32'd0);

    row = 1003;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_rv0_b", 32'(r0_rvalid), 32'd0);

    row = 1004;
    @(posedge clk); #1;
    r0_req = 1; r0_addr = 10'd5;
    @(negedge clk);
    chk("post_rst_first_gnt", 32'(r0_gnt), 32'd1);

    row = 1005;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_rv0_early", 32'(r0_rvalid), 32'd0);

    row = 1006;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_rv0_data", 32'(r0_rvalid), 32'd1);
    chk("post_rst_rdata", r0_rdata, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
